// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter with a registered one-hot grant.
// The most recently granted requester drops to lowest priority on the following cycle.
module round_robin_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] next_ptr;
    logic             found;

    // Unrolled search from ptr upward with wrap; works for non-power-of-two N.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    assign next_ptr = (int'(winner) == N - 1) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (rstn) begin
            grant <= '0;
            ptr   <= '0;
        end else if (found) begin
            grant <= N'(1) << winner;
            ptr   <= next_ptr;
        end else begin
            grant <= '0;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench for round_robin_arbiter: directed scenarios then random traffic,
// with expected grants computed from a distance-to-pointer reference model.
module tb_round_robin_arbiter;

    localparam int N = 4;

    logic         clk  = 1'b0;
    logic         rstn = 1'b1;
    logic [N-1:0] req  = '0;
    logic [N-1:0] grant;

    int           total = 0;
    int           bad   = 0;
    int           model_ptr = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    round_robin_arbiter #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .req  (req),
        .grant(grant)
    );

    task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: among requesting indices, the winner is the one with smallest
    // forward distance from the model pointer.
    task automatic applyStimulus(input logic [N-1:0] r, input logic rst);
        logic [N-1:0] expv;
        int best;
        int best_dist;
        int d;
        @(negedge clk);
        req  = r;
        rstn = rst;
        expv = '0;
        if (rst) begin
            model_ptr = 0;
        end else begin
            best      = -1;
            best_dist = N;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    d = (i - model_ptr + N) % N;
                    if (d < best_dist) begin
                        best_dist = d;
                        best      = i;
                    end
                end
            end
            if (best >= 0) begin
                expv[best] = 1'b1;
                model_ptr  = (best + 1) % N;
            end
        end
        exp_q.push_back(expv);
    endtask

    // Monitor: every edge the DUT presents a grant; compare against the queued expectation.
    initial begin
        logic [N-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("grant", grant, e);
                total++;
                if (!$onehot0(grant)) begin
                    bad++;
                    $display("[TB] FAIL onehot0: got %b expected zero or one-hot", grant);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] r;
        // Reset held two edges with full requests, then release
        applyStimulus(4'b1111, 1'b1);
        applyStimulus(4'b1111, 1'b1);
        applyStimulus(4'b1111, 1'b0);

        // Walking single requests then idle
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        applyStimulus(4'b0000, 1'b0);

        // Full contention for 8 cycles
        applyStimulus(4'b0000, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 1'b0);

        // Partial contention with wrap
        applyStimulus(4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(4'b1010, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(4'b1001, 1'b0);

        // Priority skip: ptr lands on idle index 3
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0101, 1'b0);
        applyStimulus(4'b0101, 1'b0);

        // Mid-operation reset while grant is 0100
        applyStimulus(4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(4'b1111, 1'b0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            applyStimulus(r, ($urandom_range(0, 39) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
Name: round_robin_arbiter

Overview:
- Parameterised N-way round-robin arbiter. Default is 4 requesters.
- Each cycle it grants at most one requester, as a one-hot, registered grant vector.
- Priority rotates so the most recently granted requester becomes lowest priority. No requester starves while it holds its request.
- Used wherever several masters share one resource, such as a bus, memory port or FIFO write port.

Parameters:
- N, default 4: number of requesters; sets the width of req and grant. Legal range is 2 to 32.
- PTR_W, default $clog2(N): width of the internal priority pointer. It is derived and must not be overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rstn  input  1  synchronous, active-high reset. Reset is applied on a rising clk edge while rstn = 1.
- req  input  N  request vector. Bit i = 1 means requester i wants the resource. Sampled on every rising clk edge.
- grant  output  N  one-hot grant vector, driven directly from a flop. Bit i = 1 means requester i owns the resource this cycle.

Behaviour:
- All state updates occur on the rising edge of clk. There is no asynchronous logic on the reset path.
- Reset (rstn = 1 at an edge):
  - grant <= 0.
  - Priority pointer ptr <= 0, so requester 0 has highest priority.
  - req is ignored during that cycle.
- State:
  - ptr (PTR_W bits) holds the index of the highest-priority requester.
  - The grant register holds the current grant.
- Arbitration each non-reset edge:
  - Scan req starting at index ptr, going upward and wrapping modulo N.
  - The first set bit found is the winner w.
  - grant <= one-hot(w).
  - ptr <= (w + 1) mod N.
- Latency: grant reflects req sampled at the previous edge, i.e. one cycle of latency. There is no combinational path from req to grant.
- No request (req = 0): grant <= 0 and ptr holds its value.
- Single request: that requester is granted regardless of ptr.
- Multiple simultaneous requests: the requester nearest ptr, going upward with wrap, wins. The winner drops to lowest priority on the next cycle.
- Continuous request:
  - A sole requester holding req is re-granted every cycle; there are no idle bubbles.
  - With k requesters all active, each is granted exactly once in every k consecutive cycles.
- Wrap-around: when w = N-1, ptr returns to 0.
- Request withdrawn: if a granted requester drops req, grant updates on the next edge. There is no lock or hold.
- Reset mid-operation:
  - At the reset edge grant is forced to 0 and ptr to 0, with no partial grant.
  - Arbitration resumes on the first edge with rstn = 0.
- Invariant: grant is always zero or one-hot ($onehot0), every cycle including the reset cycle.
- Invariant: grant[i] = 1 implies req[i] was 1 at the previous edge.
- Implementation: a double-width masked priority encoder, or an equivalent unrolled search, is acceptable. It must be synthesisable for any legal N.

Test Plan:
- Reset: hold rstn = 1 for 2 edges with req = 4'b1111 -> grant = 4'b0000 throughout. On the first edge after rstn = 0 -> grant = 4'b0001.
- Walking single requests: after reset, apply req = 4'b0001, 4'b0010, 4'b0100, 4'b1000 on consecutive cycles -> grant is the same sequence, each one cycle later. Then req = 0 -> grant = 4'b0000 and ptr unchanged.
- Full contention: req = 4'b1111 held for 8 cycles after reset -> grant = 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
- Partial contention with wrap: ptr = 0, req = 4'b1010 held -> grant = 0010, 1000, 0010, 1000. Then req = 4'b1001 -> grant = 0001, then 1000, alternating.
- Priority skip: grant 4'b0100 (so ptr = 3), then req = 4'b0101 -> grant = 4'b0001, because index 3 is idle and the search wraps to 0. Next cycle -> grant = 4'b0100.
- Mid-operation reset: during the full-contention run, assert rstn for one edge while grant = 4'b0100 -> grant = 4'b0000. After release -> grant = 4'b0001 (ptr back at 0). Check the $onehot0 assertion on every cycle.
